uart_rx_fifo: RTL and testbench

Byte buffer between the RS232 receiver and the SerialCommandProcessor. It captures each received byte on the receiver's single-cycle `hasRX` pulse and holds it in a circular FIFO. It presents bytes first-word-fall-through on a valid/ready port. It drops framing-error bytes, records overflow, and can raise a flow-control hold so the host pauses before bytes are lost.

---
 rtl/uart_rx_fifo.sv | 151 +++++++++++++++
 tb/tb_uart_rx_fifo.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: byte buffer between the RS232 receiver and the command processor.
// Captures each received byte on the single-cycle strobe and stores it in a circular FIFO.
// Presents bytes first-word-fall-through on a valid/ready port.
// Drops framing-error bytes, counting them in a saturating counter.
// Records a sticky overflow flag when a byte arrives while the FIFO is full.
// Optional flow control: define UART_RX_FIFO_FLOW_CTRL_EN to drive rts_hold from occupancy
// with one entry of hysteresis. Without it, rts_hold is tied low.
module uart_rx_fifo #(
   parameter int unsigned DEPTH        = 16,
   parameter int unsigned AF_THRESHOLD = 12
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [7:0]               in_data,
   input  logic                     in_valid,
   input  logic                     in_error,
   output logic [7:0]               out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   input  logic                     clear_overflow,
   output logic [7:0]               error_count,
   output logic                     rts_hold
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   // Reject configurations the pointer arithmetic and hysteresis cannot support.
   if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_rx_fifo: DEPTH must be a power of two and at least 4");
   end
   if (AF_THRESHOLD < 1 || AF_THRESHOLD > DEPTH) begin : g_bad_af
      $error("uart_rx_fifo: AF_THRESHOLD must lie in 1..DEPTH");
   end

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wp;
   logic [AW-1:0] r_rp;
   logic [CW-1:0] r_count;
   logic          r_overflow;
   logic [7:0]    r_error_count;

   logic          w_full;
   logic          w_good_byte;
   logic          w_bad_byte;
   logic          w_pop;
   logic          w_push;
   logic          w_drop_full;
   logic [CW-1:0] w_count_next;

   // Handshake decode; a pop at full frees the slot the simultaneous push needs.
   always_comb begin
      w_full       = (r_count == FULL_COUNT);
      w_good_byte  = in_valid & ~in_error;
      w_bad_byte   = in_valid & in_error;
      w_pop        = out_valid & out_ready;
      w_push       = w_good_byte & (~w_full | w_pop);
      w_drop_full  = w_good_byte & w_full & ~w_pop;
      w_count_next = r_count;
      if (w_push && !w_pop) begin
         w_count_next = r_count + 1'b1;
      end else if (w_pop && !w_push) begin
         w_count_next = r_count - 1'b1;
      end
   end

   // Storage array; deliberately not reset, contents are don't-care while empty.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wp] <= in_data;
      end
   end

   // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wp <= r_wp + 1'b1;
         end
         if (w_pop) begin
            r_rp <= r_rp + 1'b1;
         end
         r_count <= w_count_next;
      end
   end

   // Sticky overflow flag; a new drop outranks a same-cycle clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_overflow <= 1'b0;
      end else if (w_drop_full) begin
         r_overflow <= 1'b1;
      end else if (clear_overflow) begin
         r_overflow <= 1'b0;
      end
   end

   // Saturating count of bytes discarded for receive errors.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_error_count <= '0;
      end else if (w_bad_byte && r_error_count != 8'hFF) begin
         r_error_count <= r_error_count + 1'b1;
      end
   end

`ifdef UART_RX_FIFO_FLOW_CTRL_EN
   localparam logic [CW-1:0] AF_HI = CW'(AF_THRESHOLD);
   localparam logic [CW-1:0] AF_LO = CW'(AF_THRESHOLD - 1);

   logic r_rts;
   logic w_rts_next;

   // Hysteresis: set at threshold, release one entry below it (or at empty for threshold 1).
   always_comb begin
      w_rts_next = r_rts;
      if (w_count_next >= AF_HI) begin
         w_rts_next = 1'b1;
      end else if (w_count_next < AF_LO || w_count_next == '0) begin
         w_rts_next = 1'b0;
      end
   end

   // Register the hold so it tracks occupancy after each edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rts <= 1'b0;
      end else begin
         r_rts <= w_rts_next;
      end
   end

   assign rts_hold = r_rts;
`else
   assign rts_hold = 1'b0;
`endif

   assign out_data    = r_mem[r_rp];
   assign out_valid   = (r_count != '0);
   assign count       = r_count;
   assign overflow    = r_overflow;
   assign error_count = r_error_count;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic with async resets.
module tb_uart_rx_fifo;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned AF    = 12;
`ifdef UART_RX_FIFO_FLOW_CTRL_EN
   localparam bit FLOW = 1'b1;
`else
   localparam bit FLOW = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] in_data = '0;
   logic       in_valid = 1'b0;
   logic       in_error = 1'b0;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [4:0] count;
   logic       overflow;
   logic       clear_overflow = 1'b0;
   logic [7:0] error_count;
   logic       rts_hold;

   int n_checks = 0;
   int n_pass   = 0;

   uart_rx_fifo #(.DEPTH(DEPTH), .AF_THRESHOLD(AF)) dut (
      .clk            (clk),
      .rst            (rst),
      .in_data        (in_data),
      .in_valid       (in_valid),
      .in_error       (in_error),
      .out_data       (out_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .count          (count),
      .overflow       (overflow),
      .clear_overflow (clear_overflow),
      .error_count    (error_count),
      .rts_hold       (rts_hold)
   );

   always #5 clk = ~clk;

   // Reference model: a byte queue plus flags, stepped at each edge.
   byte unsigned m_q[$];
   bit           m_ovf;
   int           m_err;
   bit           m_rts;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_q.delete();
         m_ovf = 1'b0;
         m_err = 0;
         m_rts = 1'b0;
      end else begin
         bit pop;
         bit push;
         int n;
         pop  = (m_q.size() > 0) && out_ready;
         push = in_valid && !in_error && (m_q.size() < DEPTH || pop);
         if (in_valid && in_error && m_err < 255) m_err = m_err + 1;
         if (in_valid && !in_error && m_q.size() == DEPTH && !pop) m_ovf = 1'b1;
         else if (clear_overflow) m_ovf = 1'b0;
         if (pop) void'(m_q.pop_front());
         if (push) m_q.push_back(in_data);
         n = m_q.size();
         if (FLOW) begin
            if (n >= AF) m_rts = 1'b1;
            else if (n < AF - 1 || n == 0) m_rts = 1'b0;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Compare DUT outputs with the model on the falling edge of every cycle out of reset.
   always @(negedge clk) begin
      if (!rst) begin
         chk("model out_valid", {31'd0, out_valid}, {31'd0, m_q.size() != 0});
         if (m_q.size() != 0) chk("model out_data", {24'd0, out_data}, {24'd0, m_q[0]});
         chk("model count", {27'd0, count}, m_q.size());
         chk("model overflow", {31'd0, overflow}, {31'd0, m_ovf});
         chk("model error_count", {24'd0, error_count}, m_err);
         chk("model rts_hold", {31'd0, rts_hold}, {31'd0, m_rts});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] b);
      in_data  = b;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      logic [7:0] last;
      #1 rst = 1'b1;
      #12;
      chk("reset count", {27'd0, count}, 32'd0);
      chk("reset out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset overflow", {31'd0, overflow}, 32'd0);
      chk("reset error_count", {24'd0, error_count}, 32'd0);
      chk("reset rts_hold", {31'd0, rts_hold}, 32'd0);
      rst = 1'b0;
      tick();

      // Three bytes in, then drained in order.
      push(8'h41);
      push(8'h42);
      push(8'h43);
      chk("abc count", {27'd0, count}, 32'd3);
      chk("abc head", {24'd0, out_data}, 32'h41);
      out_ready = 1'b1;
      chk("pop 1", {24'd0, out_data}, 32'h41);
      tick();
      chk("pop 2", {24'd0, out_data}, 32'h42);
      tick();
      chk("pop 3", {24'd0, out_data}, 32'h43);
      tick();
      chk("drained out_valid", {31'd0, out_valid}, 32'd0);
      out_ready = 1'b0;

      // Fill, then overflow with 0xAA.
      for (int i = 0; i < 16; i++) push(8'(i));
      chk("full count", {27'd0, count}, 32'd16);
      push(8'hAA);
      chk("ovf flag", {31'd0, overflow}, 32'd1);
      chk("ovf count", {27'd0, count}, 32'd16);
      chk("ovf head", {24'd0, out_data}, 32'h00);
      clear_overflow = 1'b1;
      tick();
      clear_overflow = 1'b0;
      chk("ovf cleared", {31'd0, overflow}, 32'd0);

      // Push and pop together at full.
      out_ready = 1'b1;
      push(8'h55);
      chk("full push+pop count", {27'd0, count}, 32'd16);
      chk("full push+pop ovf", {31'd0, overflow}, 32'd0);
      last = 8'h00;
      for (int i = 0; i < 20; i++) begin
         if (out_valid) last = out_data;
         tick();
      end
      chk("last drained", {24'd0, last}, 32'h55);
      chk("drained count", {27'd0, count}, 32'd0);
      out_ready = 1'b0;

      // Error strobes saturate the error counter and store nothing.
      in_error = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 300; i++) begin
         in_data = 8'($urandom);
         tick();
      end
      in_valid = 1'b0;
      in_error = 1'b0;
      chk("err count", {27'd0, count}, 32'd0);
      chk("err saturate", {24'd0, error_count}, 32'd255);

      // Flow-control threshold and hysteresis.
      for (int i = 0; i < 11; i++) push(8'(8'h20 + i));
      chk("rts at 11", {31'd0, rts_hold}, 32'd0);
      push(8'h2B);
      chk("rts at 12", {31'd0, rts_hold}, {31'd0, FLOW});
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("rts at 11 down", {31'd0, rts_hold}, {31'd0, FLOW});
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("rts count 10", {27'd0, count}, 32'd10);
      chk("rts at 10 down", {31'd0, rts_hold}, 32'd0);

      // Reach count 7 with overflow set, then async reset mid-cycle.
      for (int i = 0; i < 7; i++) push(8'(8'h60 + i));
      chk("pre-ovf count", {27'd0, count}, 32'd16);
      push(8'hEE);
      out_ready = 1'b1;
      for (int i = 0; i < 9; i++) tick();
      out_ready = 1'b0;
      chk("pre-rst count", {27'd0, count}, 32'd7);
      chk("pre-rst ovf", {31'd0, overflow}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("async count", {27'd0, count}, 32'd0);
      chk("async out_valid", {31'd0, out_valid}, 32'd0);
      chk("async overflow", {31'd0, overflow}, 32'd0);
      chk("async error_count", {24'd0, error_count}, 32'd0);
      chk("async rts", {31'd0, rts_hold}, 32'd0);
      #2 rst = 1'b0;
      tick();
      push(8'h7E);
      chk("post-rst valid", {31'd0, out_valid}, 32'd1);
      chk("post-rst head", {24'd0, out_data}, 32'h7E);

      // Randomized traffic with changing drain pressure and occasional resets.
      for (int i = 0; i < 4000; i++) begin
         int rdy_pct;
         rdy_pct  = ((i / 250) % 3 == 0) ? 20 : (((i / 250) % 3 == 1) ? 50 : 90);
         in_valid = ($urandom_range(99) < 55);
         in_error = ($urandom_range(99) < 10);
         in_data  = 8'($urandom);
         out_ready      = ($urandom_range(99) < rdy_pct);
         clear_overflow = ($urandom_range(99) < 4);
         if (i == 1500 || i == 3200) begin
            #2 rst = 1'b1;
            #1;
            chk("rand rst count", {27'd0, count}, 32'd0);
            #2 rst = 1'b0;
         end
         tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
